horizontal_tf_seq: RTL and testbench

Parametrised horizontal twiddle-factor sequencer for the radix-16 NTT/FFT butterfly rows. It holds a per-row twiddle table that is loaded at run time and serves one shared sequencer for ROWS butterfly rows. After a start, it steps through the table, holding each factor for HOLD qualified cycles. Each factor is presented with a valid flag to the row's modular multiplier. Handshakes are start/busy/done, and each step is gated by CEN and the active stage.

---
 rtl/horizontal_tf_seq.sv | 120 ++++++++++++
 tb/tb_horizontal_tf_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/horizontal_tf_seq.sv
// Horizontal twiddle-factor sequencer: per-row run-time loaded tables, one shared player.
// Optional TF_UNITY_IDX0_EN: index 0 of every row reads as the constant 1.
module horizontal_tf_seq #(
    parameter int P_WIDTH      = 64,
    parameter int SC_WIDTH     = 3,
    parameter int ROWS         = 4,
    parameter int DEPTH        = 64,
    parameter int HOLD         = 16,
    parameter int START_IDX    = 1,
    parameter int ACTIVE_STAGE = 0,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [RW-1:0]       cfg_row,
    input  logic [IW-1:0]       cfg_addr,
    input  logic [P_WIDTH-1:0]  cfg_wdata,
    input  logic                start,
    input  logic [RW-1:0]       row_sel,
    input  logic                CEN,
    input  logic [SC_WIDTH-1:0] stage_counter,
    output logic [P_WIDTH-1:0]  Q,
    output logic                Q_valid,
    output logic                busy,
    output logic                done
);

    if (START_IDX >= DEPTH) begin : g_bad_start
        $error("horizontal_tf_seq: START_IDX must be below DEPTH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CW-1:0] CNT_LAST  = CW'(HOLD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DEPTH - 1);
    localparam logic [IW-1:0] IDX_FIRST = IW'(START_IDX);

    state_t              state;
    logic [RW-1:0]       row_q;
    logic [IW-1:0]       idx;
    logic [CW-1:0]       cnt;
    logic [P_WIDTH-1:0]  tbl [ROWS][DEPTH];
    logic [P_WIDTH-1:0]  rd_word;
    logic                q;

    assign q = ~CEN && (stage_counter == SC_WIDTH'(ACTIVE_STAGE));

    always_comb begin
`ifdef TF_UNITY_IDX0_EN
        rd_word = (idx == '0) ? P_WIDTH'(1) : tbl[row_q][idx];
`else
        rd_word = tbl[row_q][idx];
`endif
    end

    // Table has no reset so that contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (rst_n && cfg_we && (state == S_IDLE))
            tbl[cfg_row][cfg_addr] <= cfg_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            row_q   <= '0;
            idx     <= IDX_FIRST;
            cnt     <= '0;
            Q       <= '0;
            Q_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    Q_valid <= 1'b0;
                    done    <= 1'b0;
                    if (start) begin
                        row_q <= row_sel;
                        idx   <= IDX_FIRST;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    Q_valid <= q;
                    if (q) begin
                        Q <= rd_word;
                        if (cnt == CNT_LAST) begin
                            cnt <= '0;
                            if (idx == IDX_LAST) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    Q_valid <= 1'b0;
                    done    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_horizontal_tf_seq.sv
// Scoreboard bench for horizontal_tf_seq: a phase model predicts the
// handshake and queues each run's word stream; a negedge monitor checks.
module tb_horizontal_tf_seq;

    localparam int ROWS = 4;
    localparam int DEPTH = 64;
    localparam int HOLD = 16;
    localparam int START_IDX = 1;
    localparam int RW = $clog2(ROWS);
    localparam int IW = $clog2(DEPTH);
    localparam int NWORDS = (DEPTH - START_IDX) * HOLD;
    localparam int LIMIT = 6000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          cfg_we;
    logic [RW-1:0] cfg_row;
    logic [IW-1:0] cfg_addr;
    logic [63:0]   cfg_wdata;
    logic          start;
    logic [RW-1:0] row_sel;
    logic          CEN;
    logic [2:0]    stage_counter;
    logic [63:0]   Q;
    logic          Q_valid;
    logic          busy;
    logic          done;

    horizontal_tf_seq dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_we(cfg_we),
        .cfg_row(cfg_row),
        .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata),
        .start(start),
        .row_sel(row_sel),
        .CEN(CEN),
        .stage_counter(stage_counter),
        .Q(Q),
        .Q_valid(Q_valid),
        .busy(busy),
        .done(done)
    );

    typedef enum {M_IDLE, M_RUN, M_DONE} mph_t;

    mph_t        ph = M_IDLE;
    logic        ev = 1'b0;
    logic        eb = 1'b0;
    logic        ed = 1'b0;
    logic        armed = 1'b0;
    int          remaining = 0;
    int          rst_epoch = 0;
    int          seen_epoch = 0;
    int          vcount = 0;
    logic [63:0] tbl_m [ROWS][DEPTH];
    logic [63:0] exp_q [$];
    logic [63:0] last_q = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic [63:0] model_read(input int r, input int i);
`ifdef TF_UNITY_IDX0_EN
        if (i == 0) return 64'd1;
`endif
        return tbl_m[r][i];
    endfunction

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each run streams entries START_IDX..DEPTH-1, HOLD times each.
    always @(posedge clk) begin
        if (!rst_n) begin
            armed = 1'b1;
            ph = M_IDLE;
            ev = 1'b0;
            eb = 1'b0;
            ed = 1'b0;
            remaining = 0;
            rst_epoch++;
        end else begin
            case (ph)
                M_IDLE: begin
                    ev = 1'b0;
                    ed = 1'b0;
                    eb = 1'b0;
                    if (cfg_we) tbl_m[cfg_row][cfg_addr] = cfg_wdata;
                    if (start) begin
                        for (int i = START_IDX; i < DEPTH; i++)
                            for (int h = 0; h < HOLD; h++)
                                exp_q.push_back(model_read(int'(row_sel), i));
                        remaining = NWORDS;
                        ph = M_RUN;
                        eb = 1'b1;
                    end
                end
                M_RUN: begin
                    ev = !CEN && (stage_counter == 3'd0);
                    if (ev) begin
                        remaining--;
                        if (remaining == 0) begin
                            ph = M_DONE;
                            eb = 1'b0;
                            ed = 1'b1;
                        end
                    end
                end
                default: begin
                    ph = M_IDLE;
                    ev = 1'b0;
                    eb = 1'b0;
                    ed = 1'b0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            if (rst_epoch != seen_epoch) begin
                seen_epoch = rst_epoch;
                exp_q.delete();
                last_q = '0;
                vcount = 0;
            end
            check("q_valid", {63'd0, Q_valid}, {63'd0, ev});
            check("busy", {63'd0, busy}, {63'd0, eb});
            check("done", {63'd0, done}, {63'd0, ed});
            if (ev) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 64'(exp_q.size()), 64'd1);
                end else begin
                    last_q = exp_q.pop_front();
                    check("q_word", Q, last_q);
                    vcount++;
                end
            end else begin
                check("q_hold", Q, last_q);
            end
            if (ed) begin
                check("run_len", 64'(vcount), 64'(NWORDS));
                check("sb_empty", 64'(exp_q.size()), 64'd0);
                vcount = 0;
            end
        end
    end

    task automatic write_entry(input int r, input int a, input logic [63:0] d);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_row = RW'(r);
        cfg_addr = IW'(a);
        cfg_wdata = d;
    endtask

    task automatic run_seq(input int row, input int mode, input bit inj,
                           input bit rst300, input bit wr_start);
        int k;
        bit did_rst;
        @(negedge clk);
        start = 1'b1;
        row_sel = RW'(row);
        CEN = 1'b0;
        stage_counter = 3'd0;
        if (wr_start) begin
            cfg_we = 1'b1;
            cfg_row = RW'(row);
            cfg_addr = IW'(START_IDX);
            cfg_wdata = {$urandom, $urandom};
        end
        @(negedge clk);
        start = 1'b0;
        cfg_we = 1'b0;
        k = 0;
        did_rst = 1'b0;
        while (ph != M_IDLE && k < LIMIT) begin
            CEN = 1'b0;
            stage_counter = 3'd0;
            start = 1'b0;
            cfg_we = 1'b0;
            if (mode == 1) begin
                if (k >= 100 && k <= 104) CEN = 1'b1;
                if (k >= 400 && k <= 403) stage_counter = 3'd3;
            end else if (mode == 2) begin
                CEN = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 4) == 0)
                    stage_counter = 3'($urandom_range(1, 7));
            end
            if (inj && (k == 200 || k == 650)) begin
                start = 1'b1;
                row_sel = RW'(row + 1);
                cfg_we = 1'b1;
                cfg_row = RW'(row);
                cfg_addr = IW'($urandom_range(0, DEPTH - 1));
                cfg_wdata = {$urandom, $urandom};
            end
            if (rst300 && !did_rst && (NWORDS - remaining) >= 300) begin
                rst_n = 1'b0;
                did_rst = 1'b1;
            end
            if (k == 50) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            @(negedge clk);
            k++;
        end
        rst_n = 1'b1;
        start = 1'b0;
        cfg_we = 1'b0;
        check("run_bound", {63'd0, (k < LIMIT)}, 64'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int r2;
        rst_n = 1'b0;
        start = 1'b0;
        cfg_we = 1'b0;
        cfg_row = '0;
        cfg_addr = '0;
        cfg_wdata = '0;
        row_sel = '0;
        CEN = 1'b1;
        stage_counter = 3'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int r = 0; r < ROWS; r++)
            for (int a = 0; a < DEPTH; a++)
                write_entry(r, a, (r == 2) ? 64'(a + 'h100) : {$urandom, $urandom});
        @(negedge clk);
        cfg_we = 1'b0;

        run_seq(2, 0, 1'b0, 1'b0, 1'b0);
        run_seq(2, 1, 1'b0, 1'b0, 1'b0);
        r2 = $urandom_range(0, ROWS - 1);
        run_seq(r2, 2, 1'b1, 1'b0, 1'b0);
        run_seq(r2, 2, 1'b0, 1'b0, 1'b0);
        run_seq(1, 0, 1'b0, 1'b1, 1'b0);
        run_seq(1, 2, 1'b0, 1'b0, 1'b0);
        write_entry(3, 7, {$urandom, $urandom});
        write_entry(3, DEPTH - 1, {$urandom, $urandom});
        @(negedge clk);
        cfg_we = 1'b0;
        run_seq(3, 2, 1'b0, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
